// File: rtl/i2c_slave.sv
// i2c_slave: I2C target serving a NUM_REGS x 32-bit register file via an 8-bit pointer.
// Optional macro I2C_SLAVE_AUTO_INC_EN: pointer advances after every completed word.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NUM_REGS   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_out,
    output logic        busy,
    output logic        wr_strobe,
    output logic [7:0]  wr_addr,
    output logic [31:0] wr_data
);
    localparam int AW = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    state_t      state_q, state_d;
    logic        scl_s1_q, scl_s2_q, scl_p_q, sda_s1_q, sda_s2_q, sda_p_q;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  sh_q, sh_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        sda_q, sda_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic        strobe_q, strobe_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] regs_q [NUM_REGS];

    logic        scl_rise, scl_fall, start_det, stop_det, match, in_range, commit;
    logic [7:0]  nxt_ptr, head, rd_byte;
    logic [1:0]  rd_idx;
    logic [31:0] rd_word, word_in;

    assign scl_rise  = scl_s2_q & ~scl_p_q;
    assign scl_fall  = ~scl_s2_q & scl_p_q;
    assign start_det = scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;
    assign match     = sh_q[7:1] == SLAVE_ADDR;
    assign in_range  = 32'(sh_q) < NUM_REGS;

`ifdef I2C_SLAVE_AUTO_INC_EN
    assign nxt_ptr = (ptr_q + 8'd1) & 8'(NUM_REGS - 1);
`else
    assign nxt_ptr = ptr_q;
`endif

    // Read path: first byte of a read is byte 3 of the current register; after byte 0
    // the following byte comes from the (possibly advanced) next register.
    assign head    = regs_q[ptr_q[AW-1:0]][31:24];
    assign rd_idx  = byte_cnt_q + 2'd1;
    assign rd_word = (byte_cnt_q == 2'd3) ? regs_q[nxt_ptr[AW-1:0]] : regs_q[ptr_q[AW-1:0]];
    assign rd_byte = rd_word[{~rd_idx, 3'b000} +: 8];

    assign sda_out   = sda_q;
    assign busy      = busy_q;
    assign wr_strobe = strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

    // Two-stage synchronizers plus a previous-sample stage; idle bus reads high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {scl_s1_q, scl_s2_q, scl_p_q} <= 3'b111;
            {sda_s1_q, sda_s2_q, sda_p_q} <= 3'b111;
        end else begin
            {scl_s1_q, scl_s2_q, scl_p_q} <= {scl, scl_s1_q, scl_s2_q};
            {sda_s1_q, sda_s2_q, sda_p_q} <= {sda_in, sda_s1_q, sda_s2_q};
        end
    end

    // Register file is written only when a full 4-byte word has been received.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (commit) begin
            regs_q[ptr_q[AW-1:0]] <= word_in;
        end
    end

    // FSM and datapath state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            sh_q       <= '0;
            word_q     <= '0;
            ptr_q      <= '0;
            sda_q      <= 1'b1;
            busy_q     <= 1'b0;
            ack_q      <= 1'b1;
            strobe_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            sh_q       <= sh_d;
            word_q     <= word_d;
            ptr_q      <= ptr_d;
            sda_q      <= sda_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            strobe_q   <= strobe_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Next state: bus conditions take priority, bits are sampled on SCL rise, and SDA
    // changes plus state decisions happen on SCL fall.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        sh_d       = sh_q;
        word_d     = word_q;
        ptr_d      = ptr_q;
        sda_d      = sda_q;
        busy_d     = busy_q;
        ack_d      = ack_q;
        strobe_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        commit     = 1'b0;
        word_in    = word_q;
        word_in[{~byte_cnt_q, 3'b000} +: 8] = sh_q;
        if (!en) begin
            state_d = IDLE;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d    = ADDR;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            sda_d      = 1'b1;
        end else if (stop_det) begin
            state_d    = IDLE;
            sda_d      = 1'b1;
            busy_d     = 1'b0;
            byte_cnt_d = '0;
        end else if (scl_rise) begin
            if ((state_q == ADDR || state_q == REG || state_q == WDATA) && !bit_cnt_q[3]) begin
                sh_d      = {sh_q[6:0], sda_s2_q};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
            if (state_q == RDATA) bit_cnt_d = bit_cnt_q + 4'd1;
            if (state_q == RDATA_ACK) ack_d = sda_s2_q;
        end else if (scl_fall) begin
            case (state_q)
                ADDR: if (bit_cnt_q[3]) begin
                    busy_d  = match;
                    sda_d   = ~match;
                    state_d = match ? ADDR_ACK : WAIT_STOP;
                end
                ADDR_ACK: begin
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    sh_d       = head;
                    sda_d      = sh_q[0] ? head[7] : 1'b1;
                    state_d    = sh_q[0] ? RDATA : REG;
                end
                REG: if (bit_cnt_q[3]) begin
                    ptr_d   = in_range ? sh_q : ptr_q;
                    sda_d   = ~in_range;
                    state_d = in_range ? REG_ACK : WAIT_STOP;
                end
                REG_ACK, WDATA_ACK: begin
                    sda_d     = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = WDATA;
                end
                WDATA: if (bit_cnt_q[3]) begin
                    sda_d      = 1'b0;
                    state_d    = WDATA_ACK;
                    word_d     = word_in;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        commit    = 1'b1;
                        strobe_d  = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = word_in;
                        ptr_d     = nxt_ptr;
                    end
                end
                RDATA: begin
                    if (bit_cnt_q[3]) begin
                        sda_d   = 1'b1;
                        state_d = RDATA_ACK;
                    end else begin
                        sh_d  = {sh_q[6:0], 1'b0};
                        sda_d = sh_q[6];
                    end
                end
                RDATA_ACK: begin
                    if (ack_q) begin
                        sda_d   = 1'b1;
                        state_d = WAIT_STOP;
                    end else begin
                        sh_d       = rd_byte;
                        sda_d      = rd_byte[7];
                        bit_cnt_d  = '0;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        ptr_d      = (byte_cnt_q == 2'd3) ? nxt_ptr : ptr_q;
                        state_d    = RDATA;
                    end
                end
                WAIT_STOP: sda_d = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: randomized bus-level bench for i2c_slave with a register-file/pointer reference model.
module tb_i2c_slave;
    localparam int NR = 16;
    localparam int Q  = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus, sda_out, busy, wr_strobe;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

    int          errors = 0;
    int          checks = 0;
    int          sda_low = 0;
    bit          watch = 1'b0;
    logic [39:0] sq[$];
    logic [7:0]  wq[$];
    logic [31:0] mregs [NR];
    int          mptr = 0;

    assign sda_bus = sda_m & sda_out;

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(7'h50), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst), .en(en), .scl(scl), .sda_in(sda_bus), .sda_out(sda_out),
        .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always @(negedge clk) begin
        if (wr_strobe) sq.push_back({wr_addr, wr_data});
        if (watch && !sda_out) sda_low++;
    end

    initial begin
        #3ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mnxt(input int p);
`ifdef I2C_SLAVE_AUTO_INC_EN
        return (p + 1) % NR;
`else
        return p;
`endif
    endfunction

    task automatic hq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; hq(); scl = 1'b1; hq(); sda_m = 1'b0; hq(); scl = 1'b0; hq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; hq(); scl = 1'b1; hq(); sda_m = 1'b1; hq();
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; hq(); scl = 1'b1; hq(); hq(); scl = 1'b0; hq();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        sda_m = 1'b1; hq(); scl = 1'b1; hq(); ack = sda_bus; hq(); scl = 1'b0; hq();
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        sda_m = 1'b1;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            hq(); scl = 1'b1; hq(); b = {b[6:0], sda_bus}; hq(); scl = 1'b0;
        end
        sda_m = ack; hq(); scl = 1'b1; hq(); hq(); scl = 1'b0; hq();
        sda_m = 1'b1;
    endtask

    task automatic do_write(input logic [7:0] r);
        logic a;
        logic [31:0] w;
        logic [39:0] got;
        i2c_start();
        send_byte(8'hA0, a); chk("w_addr_ack", a, 0);
        send_byte(r, a); chk("w_reg_ack", a, r >= NR);
        foreach (wq[i]) begin
            send_byte(wq[i], a); chk("w_data_ack", a, r >= NR);
        end
        chk("w_busy", busy, 1);
        i2c_stop();
        repeat (4) @(negedge clk);
        chk("w_busy_stop", busy, 0);
        if (r < NR) begin
            mptr = r;
            for (int k = 0; k + 4 <= wq.size(); k += 4) begin
                w = {wq[k], wq[k+1], wq[k+2], wq[k+3]};
                if (sq.size() > 0) got = sq.pop_front();
                else got = 'x;
                chk("w_strobe", got, {8'(mptr), w});
                mregs[mptr] = w;
                mptr = mnxt(mptr);
            end
        end
        chk("w_no_extra_strobe", sq.size(), 0);
        sq.delete();
    endtask

    task automatic do_read(input logic [7:0] r, input int n);
        logic a;
        logic [7:0] b;
        int bi;
        i2c_start();
        send_byte(8'hA0, a); chk("r_addr_ack", a, 0);
        send_byte(r, a); chk("r_reg_ack", a, 0);
        i2c_start();
        send_byte(8'hA1, a); chk("r_addr1_ack", a, 0);
        mptr = r;
        bi = 0;
        for (int k = 0; k < n; k++) begin
            read_byte(k == n - 1, b);
            chk("r_data", b, mregs[mptr][8*(3-bi) +: 8]);
            bi++;
            if (bi == 4) begin
                bi = 0;
                if (k != n - 1) mptr = mnxt(mptr);
            end
        end
        chk("r_release", sda_out, 1);
        i2c_stop();
        repeat (4) @(negedge clk);
        chk("r_no_strobe", sq.size(), 0);
        sq.delete();
    endtask

    initial begin
        logic a;
        logic [7:0] v;
        int s;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        repeat (4) @(negedge clk);
        chk("rst_sda", sda_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", wr_strobe, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        wq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_write(8'h03);
        do_read(8'h03, 4);

        s = sda_low;
        watch = 1'b1;
        i2c_start();
        send_byte(8'hA2, a); chk("mm_addr_nack", a, 1);
        send_byte(8'h03, a); chk("mm_data_nack", a, 1);
        chk("mm_busy", busy, 0);
        send_byte(8'h55, a);
        i2c_stop();
        repeat (4) @(negedge clk);
        watch = 1'b0;
        chk("mm_sda_never_low", sda_low - s, 0);
        chk("mm_no_strobe", sq.size(), 0);

        wq = '{8'h12};
        do_write(8'h10);

        wq = '{8'h11, 8'h22};
        do_write(8'h05);
        do_read(8'h05, 4);

        wq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        do_write(8'h0F);
        do_read(8'h0F, 8);

        i2c_start();
        send_byte(8'hA0, a);
        send_byte(8'h07, a);
        send_byte(8'h11, a);
        v = 8'h22;
        send_bits(v);
        chk("rst_mid_ack_drive", sda_out, 0);
        rst = 1'b0;
        #1;
        chk("rst_mid_sda", sda_out, 1);
        chk("rst_mid_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sda_m = 1'b1; hq(); scl = 1'b1; hq(); hq(); scl = 1'b0; hq();
        send_byte(8'h33, a); chk("rst_mid_ignored", a, 1);
        send_byte(8'h44, a);
        i2c_stop();
        repeat (4) @(negedge clk);
        chk("rst_mid_no_strobe", sq.size(), 0);
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        mptr = 0;
        do_read(8'h03, 4);

        for (int it = 0; it < 10; it++) begin
            int r, n;
            r = $urandom_range(0, NR + 3);
            n = $urandom_range(0, 8);
            wq = {};
            for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
            do_write(8'(r));
            do_read(8'($urandom_range(0, NR - 1)), $urandom_range(1, 6));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
I2C target (slave) for the team's i2c_master. It uses the same split-SDA convention: sda_in from the bus, sda_out as an open-drain pull-down, where 0 drives low and 1 releases. SCL/SDA are oversampled on the system clock, and the block serves a NUM_REGS x 32-bit register file addressed by an 8-bit register pointer. Words travel as 4 bytes, MSB byte first, MSB bit first, with a write strobe exported to fabric.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit bus address this target answers to
NUM_REGS, 16, number of 32-bit registers (power of two, 2..256)

Ports:
clk  input  1  system clock; must be >= 8x SCL frequency
rst  input  1  asynchronous reset, active-low
en  input  1  1 = respond on bus; 0 = sda_out held 1, FSM forced to IDLE
scl  input  1  serial clock from master (asynchronous)
sda_in  input  1  serial data from bus (asynchronous)
sda_out  output  1  open-drain data drive (0 = pull low, 1 = release)
busy  output  1  1 from address match until STOP or return to IDLE
wr_strobe  output  1  one-clk pulse when a 32-bit word is committed
wr_addr  output  8  register index of committed word
wr_data  output  32  committed word

Behaviour:
- Reset (rst=0): sda_out=1, busy=0, wr_strobe=0, wr_addr=0, wr_data=0; pointer=0; all registers=0; FSM=IDLE.
- Input conditioning:
  - scl and sda_in each pass through 2-FF synchronizers, then a prev-sample register.
  - Bus-to-internal event latency is 3 clk.
  - START: sda falls while scl=1. STOP: sda rises while scl=1.
  - Data is sampled on the scl rising edge; sda_out updates on the clk after a scl falling edge.
- START or repeated START, from any state: go to ADDR, clear bit counter, release sda_out.
- STOP, from any state: go to IDLE, release sda_out, busy=0, discard any partial word.
- FSM states:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. If bits[7:1]==SLAVE_ADDR, go to ADDR_ACK and set busy=1; otherwise go to WAIT_STOP with sda_out=1.
  - ADDR_ACK: drive 0 for one SCL period. Then R/W=0 goes to REG; R/W=1 loads the shift register with reg[pointer] byte 3 and goes to RDATA.
  - REG: shift 8 bits. If value < NUM_REGS, load pointer and go to REG_ACK (drive 0). Otherwise NACK (release) and go to WAIT_STOP.
  - REG_ACK: go to WDATA.
  - WDATA: shift 8 bits into word byte [3-byte_cnt], then go to WDATA_ACK (drive 0).
    - On the 4th byte: reg[pointer] <= word. wr_strobe=1 for one clk, with wr_addr=pointer and wr_data=word. byte_cnt=0.
    - Pointer update follows the optional feature below.
  - RDATA: drive shift-register MSB first; after 8 bits release sda_out and go to RDATA_ACK.
  - RDATA_ACK: sample the master's bit at scl rise.
    - ACK (0): load the next byte and go to RDATA. After byte 0, the pointer advances per the feature and byte 3 of the new register is loaded.
    - NACK (1): go to WAIT_STOP.
  - WAIT_STOP: sda_out=1; wait for STOP or START.
- Word commit happens only after all 4 bytes are received; a STOP or START mid-word leaves the register unchanged.
- A bus write and a wr_strobe never conflict, since the fabric has no write port; the register file is written only by the FSM.
- Pointer persists across transactions, so a write of the register byte only, then Sr + read, reads that register.
- Reset asserted mid-transfer: immediate release of sda_out and all outputs return to reset values; the remainder of the transfer is ignored until the next START.

Optional Feature:
I2C_SLAVE_AUTO_INC_EN
- Defined: after each completed word (write commit, or read of byte 0 ACKed), pointer = (pointer+1) mod NUM_REGS, so consecutive words access consecutive registers and wrap at NUM_REGS-1 -> 0.
- Undefined: pointer never changes inside a transaction; further words re-write or re-read the same register.

Test Plan:
- Write: START, 0xA0, 0x03, DE AD BE EF, STOP -> ACK on all 6 bytes; one wr_strobe with wr_addr=0x03, wr_data=0xDEADBEEF; busy falls at STOP.
- Read: START, 0xA0, 0x03, Sr, 0xA1, then master ACK x3 and NACK on the last byte -> sda_out serializes DE, AD, BE, EF; released after the NACK.
- Address mismatch: START, 0xA2, data... -> sda_out stays 1 throughout; busy=0; no wr_strobe.
- Out-of-range register: START, 0xA0, 0x10 (NUM_REGS=16) -> address ACKed, register byte NACKed, then WAIT_STOP.
- Partial word: START, 0xA0, 0x05, 11 22, STOP -> no wr_strobe; a subsequent read of reg 5 returns 0x00000000.
- Auto-inc (macro on): write reg 0x0F with 8 data bytes 0x01..0x08 -> two strobes, (0x0F, 0x01020304) then (0x00, 0x05060708); with the macro off, both strobes target 0x0F. Additionally, pulse rst low during byte 2 -> sda_out=1 immediately and no strobe.
